// File: rtl/step_seq_ctrl_if.sv
// Transport/tempo bus between the sequencer controller and the pad/sound logic.
// The master drives requests and tempo; the slave (step_seq_ctrl) drives step status.
interface step_seq_ctrl_if #(
    parameter int DIV_W = 8,
    parameter int BAR_W = 2
);
    // Handshake: START/STOP/PAUSE are single-cycle request pulses with no ready;
    // each one is acted on at the edge it is sampled. TEMPO is level, sampled every
    // cycle. TICK and DONE are single-cycle status pulses with no acknowledge.
    logic             START;
    logic             STOP;
    logic             PAUSE;
    logic [DIV_W-1:0] TEMPO;
    logic             TICK;
    logic [1:0]       STEP;
    logic [BAR_W-1:0] BAR;
    logic             CR;
    logic             RUNNING;
    logic             DONE;

    modport master (
        output START, STOP, PAUSE, TEMPO,
        input  TICK, STEP, BAR, CR, RUNNING, DONE
    );

    modport slave (
        input  START, STOP, PAUSE, TEMPO,
        output TICK, STEP, BAR, CR, RUNNING, DONE
    );
endinterface

// File: rtl/step_seq_ctrl.sv
// Tempo divider and IDLE/RUN/PAUSE transport FSM for the 4-step beat counter.
// Define STEP_SEQ_LOOP_EN to loop at end-of-sequence instead of returning to IDLE.
module step_seq_ctrl #(
    parameter int DIV_W = 8,
    parameter int BAR_W = 2
) (
    input  logic                CLK,
    input  logic                RST,
    step_seq_ctrl_if.slave      bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [BAR_W-1:0] BAR_ONE  = {{(BAR_W-1){1'b0}}, 1'b1};
    localparam logic [BAR_W-1:0] BAR_LAST = {BAR_W{1'b1}};

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       step_q, step_d;
    logic [BAR_W-1:0] bar_q, bar_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic step_due;
    logic seq_end;

    // >= rather than == so a TEMPO drop below the running count advances at once.
    assign step_due = (div_q >= bus.TEMPO);
    assign seq_end  = step_due && (step_q == 2'd3) && (bar_q == BAR_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        step_d  = step_q;
        bar_d   = bar_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                step_d = '0;
                bar_d  = '0;
                // STOP outranks START even though IDLE has nothing to stop.
                if (bus.START && !bus.STOP) begin
                    state_d = ST_RUN;
                    tick_d  = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.STOP) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    step_d  = '0;
                    bar_d   = '0;
                end else if (bus.START) begin
                    div_d  = '0;
                    step_d = '0;
                    bar_d  = '0;
                    tick_d = 1'b1;
                end else if (bus.PAUSE) begin
                    state_d = ST_PAUSE;
                end else if (step_due) begin
                    div_d  = '0;
                    step_d = step_q + 2'd1;
                    tick_d = 1'b1;
                    if (step_q == 2'd3) begin
                        bar_d = bar_q + BAR_ONE;
                    end
                    if (seq_end) begin
                        done_d = 1'b1;
`ifdef STEP_SEQ_LOOP_EN
                        state_d = ST_RUN;
`else
                        state_d = ST_IDLE;
                        tick_d  = 1'b0;
`endif
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            ST_PAUSE: begin
                if (bus.STOP) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    step_d  = '0;
                    bar_d   = '0;
                end else if (bus.START || bus.PAUSE) begin
                    // Resume only: counters continue from where they froze.
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                step_d  = '0;
                bar_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            step_q  <= '0;
            bar_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            step_q  <= step_d;
            bar_q   <= bar_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign bus.TICK    = tick_q;
    assign bus.STEP    = step_q;
    assign bus.BAR     = bar_q;
    assign bus.CR      = (step_q == 2'd3);
    assign bus.RUNNING = (state_q == ST_RUN);
    assign bus.DONE    = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Self-checking bench for step_seq_ctrl: directed scenarios plus random transport
// traffic checked against a step-position model. Honours STEP_SEQ_LOOP_EN.
module tb_step_seq_ctrl;

    localparam int DIV_W  = 8;
    localparam int BAR_W  = 2;
    localparam int NBARS  = 1 << BAR_W;
    localparam int NSTEPS = 4 * NBARS;
    localparam int VW     = 6 + BAR_W;

    logic       CLK;
    logic       RST;
    logic [1:0] dbg_state;

    step_seq_ctrl_if #(.DIV_W(DIV_W), .BAR_W(BAR_W)) bus();

    step_seq_ctrl #(.DIV_W(DIV_W), .BAR_W(BAR_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: mode 0=idle 1=run 2=paused; pos = steps since sequence start,
    // cnt = cycles already spent in the current step.
    int m_mode, m_pos, m_cnt;
    bit m_tick, m_done;

    logic [1:0] exp_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_cnt = 0; m_tick = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit start, input bit stop, input bit pause, input int tempo);
        m_tick = 0;
        m_done = 0;
        if (stop) begin
            m_mode = 0; m_pos = 0; m_cnt = 0;
        end else if (start && m_mode != 2) begin
            m_mode = 1; m_pos = 0; m_cnt = 0; m_tick = 1;
        end else if ((start || pause) && m_mode == 2) begin
            m_mode = 1;
        end else if (pause && m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 1) begin
            if (m_cnt >= tempo) begin
                m_cnt = 0;
                m_pos = m_pos + 1;
                m_tick = 1;
                if (m_pos == NSTEPS) begin
                    m_pos  = 0;
                    m_done = 1;
`ifndef STEP_SEQ_LOOP_EN
                    m_mode = 0;
                    m_tick = 0;
`endif
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        int s, b;
        s = m_pos % 4;
        b = (m_pos / 4) % NBARS;
        return {m_tick, 2'(s), BAR_W'(b), (s == 3), (m_mode == 1), m_done};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.TICK, bus.STEP, bus.BAR, bus.CR, bus.RUNNING, bus.DONE};
    endfunction

    task automatic drive(input bit start, input bit stop, input bit pause);
        bus.START = start;
        bus.STOP  = stop;
        bus.PAUSE = pause;
    endtask

    task automatic tick_clk();
        @(posedge CLK);
        if (!RST) model_reset();
        else model_edge(bus.START, bus.STOP, bus.PAUSE, int'(bus.TEMPO));
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        drive(0, 0, 0);
        bus.TEMPO = '0;
        model_reset();
        #3;
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), {VW{1'b0}});
        end
        drive(1, 0, 0);
        tick_clk();
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=%h", obs_vec(), {VW{1'b0}});
        end
        drive(0, 0, 0);
        RST = 1'b1;
        tick_clk();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_tempo();
        int last_tick, n_ticks;
        logic [1:0] want;
        bus.TEMPO = 8'd3;
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        drive(1, 0, 0);
        tick_clk();
        drive(0, 0, 0);
        want = exp_q.pop_front();
        n_checks++;
        if (!(bus.TICK === 1'b1 && bus.STEP === want && bus.RUNNING === 1'b1)) begin
            n_fail++;
            $display("FAIL tempo_start tick=%b step=%0d run=%b exp tick=1 step=%0d run=1",
                     bus.TICK, bus.STEP, bus.RUNNING, want);
        end
        last_tick = cyc;
        n_ticks   = 1;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL tempo_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (bus.TICK === 1'b1) begin
                n_ticks++;
                n_checks++;
                if (cyc - last_tick != 4) begin
                    n_fail++;
                    $display("FAIL tempo_period got=%0d exp=4", cyc - last_tick);
                end
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    n_checks++;
                    if (bus.STEP !== want) begin
                        n_fail++;
                        $display("FAIL tempo_step got=%0d exp=%0d", bus.STEP, want);
                    end
                end
                if (n_ticks == 5) begin
                    n_checks++;
                    if (bus.BAR !== BAR_W'(1)) begin
                        n_fail++;
                        $display("FAIL tempo_bar got=%0d exp=1", bus.BAR);
                    end
                end
                last_tick = cyc;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL tempo_ticks_seen left=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_pause();
        logic [1:0]       s_step;
        logic [BAR_W-1:0] s_bar;
        int n;
        drive(0, 1, 0);
        tick_clk();
        bus.TEMPO = 8'd7;
        drive(1, 0, 0);
        tick_clk();
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) tick_clk();
        drive(0, 0, 1);
        tick_clk();
        drive(0, 0, 0);
        s_step = bus.STEP;
        s_bar  = bus.BAR;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            n_checks++;
            if (!(bus.TICK === 1'b0 && bus.STEP === s_step && bus.BAR === s_bar &&
                  bus.RUNNING === 1'b0 && obs_vec() === exp_vec())) begin
                n_fail++;
                $display("FAIL pause_frozen cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 1);
        tick_clk();
        drive(0, 0, 0);
        n_checks++;
        if (!(bus.RUNNING === 1'b1 && bus.TICK === 1'b0)) begin
            n_fail++;
            $display("FAIL pause_resume run=%b tick=%b exp run=1 tick=0", bus.RUNNING, bus.TICK);
        end
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (bus.TICK !== 1'b1 && n < 20);
        n_checks++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL pause_next_tick got=%0d exp=3", n);
        end
    endtask

    task automatic test_priority();
        int n;
        drive(1, 1, 0);
        tick_clk();
        drive(0, 0, 0);
        n_checks++;
        if (!(bus.RUNNING === 1'b0 && bus.STEP === 2'd0 && bus.BAR === '0 && bus.TICK === 1'b0)) begin
            n_fail++;
            $display("FAIL prio_stop got=%h exp=%h", obs_vec(), {VW{1'b0}});
        end
        bus.TEMPO = 8'd1;
        drive(1, 0, 0);
        tick_clk();
        drive(0, 0, 0);
        n = 0;
        while (!(bus.STEP === 2'd2 && bus.BAR === BAR_W'(1)) && n < 40) begin
            tick_clk();
            n++;
        end
        n_checks++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL prio_reach_step2 got=timeout exp=step2_bar1");
        end
        drive(1, 0, 0);
        tick_clk();
        drive(0, 0, 0);
        n_checks++;
        if (!(bus.STEP === 2'd0 && bus.BAR === '0 && bus.TICK === 1'b1 && bus.RUNNING === 1'b1)) begin
            n_fail++;
            $display("FAIL prio_restart got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick_clk();
        n_checks++;
        if (!(bus.TICK === 1'b0 && bus.STEP === 2'd0)) begin
            n_fail++;
            $display("FAIL prio_restart_hold tick=%b step=%0d exp tick=0 step=0", bus.TICK, bus.STEP);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.TEMPO = 8'd0;
        drive(1, 0, 0);
        tick_clk();
        drive(0, 0, 0);
        n = 0;
        while (!(bus.STEP === 2'd2 && bus.BAR === BAR_W'(1)) && n < 20) begin
            tick_clk();
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL rstmid_reach got=timeout exp=step2_bar1");
        end
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async got=%h exp=%h", obs_vec(), {VW{1'b0}});
        end
        drive(1, 0, 0);
        tick_clk();
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL rstmid_hold got=%h exp=%h", obs_vec(), {VW{1'b0}});
        end
        drive(0, 0, 0);
        RST = 1'b1;
        tick_clk();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rstmid_release got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_end_of_seq();
        bus.TEMPO = 8'd0;
        drive(1, 0, 0);
        tick_clk();
        drive(0, 0, 0);
        for (int i = 1; i < NSTEPS; i++) begin
            tick_clk();
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL eos_run i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        tick_clk();
        n_checks++;
`ifdef STEP_SEQ_LOOP_EN
        if (!(bus.DONE === 1'b1 && bus.STEP === 2'd0 && bus.BAR === '0 &&
              bus.RUNNING === 1'b1 && bus.TICK === 1'b1)) begin
            n_fail++;
            $display("FAIL eos_loop got=%h exp done=1 step=0 bar=0 run=1 tick=1", obs_vec());
        end
`else
        if (!(bus.DONE === 1'b1 && bus.STEP === 2'd0 && bus.BAR === '0 &&
              bus.RUNNING === 1'b0 && bus.TICK === 1'b0)) begin
            n_fail++;
            $display("FAIL eos_idle got=%h exp done=1 step=0 bar=0 run=0 tick=0", obs_vec());
        end
`endif
        tick_clk();
        n_checks++;
        if (bus.DONE !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL eos_done_pulse got=%h exp=%h", obs_vec(), exp_vec());
        end
        drive(0, 1, 0);
        tick_clk();
        drive(0, 0, 0);
    endtask

    task automatic test_tempo_change();
        int n;
        bus.TEMPO = 8'd10;
        drive(1, 0, 0);
        tick_clk();
        drive(0, 0, 0);
        for (int i = 0; i < 8; i++) tick_clk();
        n_checks++;
        if (!(bus.TICK === 1'b0 && bus.STEP === 2'd0)) begin
            n_fail++;
            $display("FAIL tchg_before tick=%b step=%0d exp tick=0 step=0", bus.TICK, bus.STEP);
        end
        bus.TEMPO = 8'd2;
        tick_clk();
        n_checks++;
        if (!(bus.TICK === 1'b1 && bus.STEP === 2'd1)) begin
            n_fail++;
            $display("FAIL tchg_advance tick=%b step=%0d exp tick=1 step=1", bus.TICK, bus.STEP);
        end
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (bus.TICK !== 1'b1 && n < 20);
        n_checks++;
        if (n != 3 || bus.STEP !== 2'd2) begin
            n_fail++;
            $display("FAIL tchg_period got=%0d step=%0d exp=3 step=2", n, bus.STEP);
        end
        drive(0, 1, 0);
        tick_clk();
        drive(0, 0, 0);
    endtask

    task automatic test_random();
        int r;
        bus.TEMPO = 8'd1;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)       drive(1, 0, 0);
            else if (r < 6)  drive(0, 1, 0);
            else if (r < 12) drive(0, 0, 1);
            else if (r < 13) drive(1, 1, 1);
            else             drive(0, 0, 0);
            if ($urandom_range(0, 29) == 0) bus.TEMPO = DIV_W'($urandom_range(0, 4));
            tick_clk();
            drive(0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_tempo();
        test_pause();
        test_priority();
        test_reset_mid();
        test_end_of_seq();
        test_tempo_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
